// File: rtl/div_seq_if.sv
// div_seq_if: start/done handshake, operand and result bundle for the sequential divider.
interface div_seq_if #(
    parameter int DW = 8
);
    logic          start;
    logic [DW-1:0] dvdnd_val;
    logic [DW-1:0] dvsr_val;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          dvz;

    modport master (
        output start, dvdnd_val, dvsr_val,
        input  busy, done, quotient, remainder, dvz
    );

    modport slave (
        input  start, dvdnd_val, dvsr_val,
        output busy, done, quotient, remainder, dvz
    );
endinterface

// File: rtl/div_seq.sv
// div_seq: sequential restoring (shift-subtract) divider, one quotient bit per cycle.
// `define DIV_SIGNED_EN for two's-complement operands (adds a one-cycle FIX state).
module div_seq #(
    parameter  int DW = 8,
    localparam int CW = $clog2(DW + 1)
) (
    input  logic     i_clk,
    input  logic     i_rst,
    div_seq_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic [DW:0]   rem_r, rem_nxt_s;
    logic [DW-1:0] quo_r, quo_nxt_s;
    logic [DW-1:0] dvsr_r, dvsr_nxt_s;
    logic [DW-1:0] dvdnd_r, dvdnd_nxt_s;
    logic [DW-1:0] quotient_r, quotient_nxt_s;
    logic [DW-1:0] remainder_r, remainder_nxt_s;
    logic          busy_r, busy_nxt_s;
    logic          done_r, done_nxt_s;
    logic          dvz_r, dvz_nxt_s;

    logic [2*DW:0] pair_s;
    logic [DW:0]   trial_s, rem_iter_s;
    logic [DW-1:0] quo_iter_s;
    logic [DW-1:0] dvdnd_mag_s, dvsr_mag_s;

    // One restoring step: shift {R,Q} left, trial-subtract the divisor, keep or restore.
    assign pair_s     = {rem_r, quo_r} << 1;
    assign trial_s    = pair_s[2*DW:DW] - {1'b0, dvsr_r};
    assign rem_iter_s = trial_s[DW] ? pair_s[2*DW:DW] : trial_s;
    assign quo_iter_s = pair_s[DW-1:0] | {{(DW-1){1'b0}}, ~trial_s[DW]};

`ifdef DIV_SIGNED_EN
    logic sgn_q_r, sgn_q_nxt_s;
    logic sgn_rem_r, sgn_rem_nxt_s;

    function automatic logic [DW-1:0] negate(input logic [DW-1:0] v);
        return ~v + DW'(1);
    endfunction

    assign dvdnd_mag_s = dvdnd_r[DW-1] ? negate(dvdnd_r) : dvdnd_r;
    assign dvsr_mag_s  = dvsr_r[DW-1]  ? negate(dvsr_r)  : dvsr_r;
`else
    assign dvdnd_mag_s = dvdnd_r;
    assign dvsr_mag_s  = dvsr_r;
`endif

    // Next-state and next-register values; outputs are computed for the state being entered.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        rem_nxt_s       = rem_r;
        quo_nxt_s       = quo_r;
        dvsr_nxt_s      = dvsr_r;
        dvdnd_nxt_s     = dvdnd_r;
        quotient_nxt_s  = quotient_r;
        remainder_nxt_s = remainder_r;
        dvz_nxt_s       = dvz_r;
        busy_nxt_s      = 1'b0;
        done_nxt_s      = 1'b0;
`ifdef DIV_SIGNED_EN
        sgn_q_nxt_s     = sgn_q_r;
        sgn_rem_nxt_s   = sgn_rem_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    dvdnd_nxt_s     = bus.dvdnd_val;
                    dvsr_nxt_s      = bus.dvsr_val;
                    quotient_nxt_s  = {DW{1'b0}};
                    remainder_nxt_s = {DW{1'b0}};
                    dvz_nxt_s       = 1'b0;
                    state_nxt_s     = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                rem_nxt_s  = {(DW+1){1'b0}};
                quo_nxt_s  = dvdnd_mag_s;
                dvsr_nxt_s = dvsr_mag_s;
                cnt_nxt_s  = CW'(DW);
`ifdef DIV_SIGNED_EN
                sgn_q_nxt_s   = dvdnd_r[DW-1] ^ dvsr_r[DW-1];
                sgn_rem_nxt_s = dvdnd_r[DW-1];
`endif
                if (dvsr_r == {DW{1'b0}}) begin
                    quotient_nxt_s  = {DW{1'b1}};
                    remainder_nxt_s = dvdnd_r;
                    dvz_nxt_s       = 1'b1;
                    state_nxt_s     = ST_DONE;
                end else begin
                    state_nxt_s = ST_ITER;
                end
            end
            ST_ITER: begin
                rem_nxt_s = rem_iter_s;
                quo_nxt_s = quo_iter_s;
                cnt_nxt_s = cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
`ifdef DIV_SIGNED_EN
                    state_nxt_s = ST_FIX;
`else
                    quotient_nxt_s  = quo_iter_s;
                    remainder_nxt_s = rem_iter_s[DW-1:0];
                    state_nxt_s     = ST_DONE;
`endif
                end else begin
                    state_nxt_s = ST_ITER;
                end
            end
`ifdef DIV_SIGNED_EN
            ST_FIX: begin
                quotient_nxt_s  = sgn_q_r ? negate(quo_r) : quo_r;
                remainder_nxt_s = sgn_rem_r ? negate(rem_r[DW-1:0]) : rem_r[DW-1:0];
                state_nxt_s     = ST_DONE;
            end
`endif
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        done_nxt_s = (state_nxt_s == ST_DONE);
    end

    // State, datapath and output registers; reset aborts any division in flight.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            rem_r       <= {(DW+1){1'b0}};
            quo_r       <= {DW{1'b0}};
            dvsr_r      <= {DW{1'b0}};
            dvdnd_r     <= {DW{1'b0}};
            quotient_r  <= {DW{1'b0}};
            remainder_r <= {DW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dvz_r       <= 1'b0;
`ifdef DIV_SIGNED_EN
            sgn_q_r     <= 1'b0;
            sgn_rem_r   <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            rem_r       <= rem_nxt_s;
            quo_r       <= quo_nxt_s;
            dvsr_r      <= dvsr_nxt_s;
            dvdnd_r     <= dvdnd_nxt_s;
            quotient_r  <= quotient_nxt_s;
            remainder_r <= remainder_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            dvz_r       <= dvz_nxt_s;
`ifdef DIV_SIGNED_EN
            sgn_q_r     <= sgn_q_nxt_s;
            sgn_rem_r   <= sgn_rem_nxt_s;
`endif
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.dvz       = dvz_r;
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed self-checking bench for div_seq (DW=8), cycle numbers relative to the start edge.
module tb_div_seq;
    localparam int DW = 8;
`ifdef DIV_SIGNED_EN
    localparam int LAT = DW + 3;
`else
    localparam int LAT = DW + 2;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    div_seq_if #(.DW(DW)) tb_bus ();
    div_seq #(.DW(DW)) dut (.i_clk(clk), .i_rst(rst_n), .bus(tb_bus));

    always #5 clk = ~clk;

    task automatic do_start(input logic [DW-1:0] a, input logic [DW-1:0] b);
        @(negedge clk);
        tb_bus.dvdnd_val = a;
        tb_bus.dvsr_val  = b;
        tb_bus.start     = 1'b1;
        @(posedge clk);
        #1;
        tb_bus.start     = 1'b0;
        tb_bus.dvdnd_val = 8'hA5;
        tb_bus.dvsr_val  = 8'h3C;
    endtask

    // Samples cycles 1..40 on the falling edge; optional stray 1/1 start pulse in cycle inj.
    task automatic wait_done(input int inj, output int cyc, output logic [63:0] bmap);
        cyc  = -1;
        bmap = 64'd0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (inj != 0 && k == inj + 1) tb_bus.start = 1'b0;
            bmap[k] = tb_bus.busy;
            if (k == inj) begin
                tb_bus.start = 1'b1; tb_bus.dvdnd_val = 8'd1; tb_bus.dvsr_val = 8'd1;
            end
            if (tb_bus.done === 1'b1) begin
                cyc = k;
                break;
            end
        end
        tb_bus.start = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++; if ({tb_bus.busy, tb_bus.done, tb_bus.dvz} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000", {tb_bus.busy, tb_bus.done, tb_bus.dvz}); end
        n_checks++; if ({tb_bus.quotient, tb_bus.remainder} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_results: got %h expected 0000", {tb_bus.quotient, tb_bus.remainder}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int cyc; logic [63:0] bmap; logic [63:0] bexp;
        bexp = (64'd1 << (LAT + 1)) - 64'd2;
        do_start(8'd100, 8'd7);
        wait_done(0, cyc, bmap);
        n_checks++; if (cyc !== LAT) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", cyc, LAT); end
        n_checks++; if (tb_bus.quotient !== 8'd14) begin n_fail++; $display("FAIL basic_q: got %0d expected 14", tb_bus.quotient); end
        n_checks++; if (tb_bus.remainder !== 8'd2) begin n_fail++; $display("FAIL basic_r: got %0d expected 2", tb_bus.remainder); end
        n_checks++; if (tb_bus.dvz !== 1'b0) begin n_fail++; $display("FAIL basic_dvz: got %b expected 0", tb_bus.dvz); end
        n_checks++; if (bmap !== bexp) begin n_fail++; $display("FAIL basic_busy_map: got %h expected %h", bmap, bexp); end
        @(negedge clk);
        n_checks++; if ({tb_bus.busy, tb_bus.done} !== 2'b00) begin
            n_fail++; $display("FAIL basic_after_done: got busy/done %b expected 00", {tb_bus.busy, tb_bus.done}); end
    endtask

    task automatic test_hold;
        int cyc; logic [63:0] bmap;
        do_start(8'd255, 8'd1);
        wait_done(0, cyc, bmap);
        n_checks++; if ({tb_bus.quotient, tb_bus.remainder} !== {8'd255, 8'd0}) begin
            n_fail++; $display("FAIL div255_1: got q=%0d r=%0d expected q=255 r=0", tb_bus.quotient, tb_bus.remainder); end
        do_start(8'd3, 8'd10);
        wait_done(0, cyc, bmap);
        n_checks++; if (cyc !== LAT) begin n_fail++; $display("FAIL div3_10_latency: got %0d expected %0d", cyc, LAT); end
        n_checks++; if ({tb_bus.quotient, tb_bus.remainder} !== {8'd0, 8'd3}) begin
            n_fail++; $display("FAIL div3_10: got q=%0d r=%0d expected q=0 r=3", tb_bus.quotient, tb_bus.remainder); end
        repeat (5) @(negedge clk);
        n_checks++; if ({tb_bus.quotient, tb_bus.remainder, tb_bus.done} !== {8'd0, 8'd3, 1'b0}) begin
            n_fail++; $display("FAIL hold: got q=%0d r=%0d done=%b expected q=0 r=3 done=0", tb_bus.quotient, tb_bus.remainder, tb_bus.done); end
    endtask

    task automatic test_div_zero;
        int cyc; logic [63:0] bmap;
        do_start(8'd5, 8'd0);
        wait_done(0, cyc, bmap);
        n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL dvz_latency: got %0d expected 2", cyc); end
        n_checks++; if (tb_bus.quotient !== 8'hFF) begin n_fail++; $display("FAIL dvz_q: got %h expected ff", tb_bus.quotient); end
        n_checks++; if (tb_bus.remainder !== 8'd5) begin n_fail++; $display("FAIL dvz_r: got %0d expected 5", tb_bus.remainder); end
        n_checks++; if (tb_bus.dvz !== 1'b1) begin n_fail++; $display("FAIL dvz_flag: got %b expected 1", tb_bus.dvz); end
        do_start(8'd9, 8'd3);
        wait_done(0, cyc, bmap);
        n_checks++; if (tb_bus.dvz !== 1'b0) begin n_fail++; $display("FAIL dvz_cleared: got %b expected 0", tb_bus.dvz); end
        n_checks++; if ({tb_bus.quotient, tb_bus.remainder} !== {8'd3, 8'd0}) begin
            n_fail++; $display("FAIL div9_3: got q=%0d r=%0d expected q=3 r=0", tb_bus.quotient, tb_bus.remainder); end
    endtask

    task automatic test_back_to_back;
        int cyc; logic [63:0] bmap; logic [15:0] exp_qr;
`ifdef DIV_SIGNED_EN
        exp_qr = {8'hFA, 8'hFE};
`else
        exp_qr = {8'd22, 8'd2};
`endif
        do_start(8'd200, 8'd9);
        wait_done(5, cyc, bmap);
        n_checks++; if (cyc !== LAT) begin n_fail++; $display("FAIL ignore_latency: got %0d expected %0d", cyc, LAT); end
        n_checks++; if ({tb_bus.quotient, tb_bus.remainder} !== exp_qr) begin
            n_fail++; $display("FAIL div200_9: got %h expected %h", {tb_bus.quotient, tb_bus.remainder}, exp_qr); end
        tb_bus.start = 1'b1; tb_bus.dvdnd_val = 8'd50; tb_bus.dvsr_val = 8'd7;
        @(negedge clk);
        n_checks++; if ({tb_bus.busy, tb_bus.done} !== 2'b00) begin
            n_fail++; $display("FAIL start_in_done: got busy/done %b expected 00", {tb_bus.busy, tb_bus.done}); end
        @(posedge clk);
        #1;
        tb_bus.start = 1'b0;
        wait_done(0, cyc, bmap);
        n_checks++; if (cyc !== LAT) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", cyc, LAT); end
        n_checks++; if ({tb_bus.quotient, tb_bus.remainder} !== {8'd7, 8'd1}) begin
            n_fail++; $display("FAIL div50_7: got q=%0d r=%0d expected q=7 r=1", tb_bus.quotient, tb_bus.remainder); end
    endtask

    task automatic test_abort_reset;
        int cyc; logic [63:0] bmap; bit saw_done;
        do_start(8'd200, 8'd9);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({tb_bus.busy, tb_bus.done, tb_bus.dvz, tb_bus.quotient, tb_bus.remainder} !== 19'd0) begin
            n_fail++; $display("FAIL abort_outputs: got %h expected 0", {tb_bus.busy, tb_bus.done, tb_bus.dvz, tb_bus.quotient, tb_bus.remainder}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (tb_bus.done !== 1'b0 || tb_bus.busy !== 1'b0) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got activity=%b expected 0", saw_done); end
        do_start(8'd50, 8'd5);
        wait_done(0, cyc, bmap);
        n_checks++; if (cyc !== LAT) begin n_fail++; $display("FAIL after_abort_latency: got %0d expected %0d", cyc, LAT); end
        n_checks++; if ({tb_bus.quotient, tb_bus.remainder} !== {8'd10, 8'd0}) begin
            n_fail++; $display("FAIL div50_5: got q=%0d r=%0d expected q=10 r=0", tb_bus.quotient, tb_bus.remainder); end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed;
        int cyc; logic [63:0] bmap;
        do_start(8'h9C, 8'd7);
        wait_done(0, cyc, bmap);
        n_checks++; if (cyc !== DW + 3) begin n_fail++; $display("FAIL signed_latency: got %0d expected %0d", cyc, DW + 3); end
        n_checks++; if ({tb_bus.quotient, tb_bus.remainder} !== {8'hF2, 8'hFE}) begin
            n_fail++; $display("FAIL sdiv_m100_7: got %h expected f2fe", {tb_bus.quotient, tb_bus.remainder}); end
        do_start(8'h64, 8'hF9);
        wait_done(0, cyc, bmap);
        n_checks++; if ({tb_bus.quotient, tb_bus.remainder} !== {8'hF2, 8'h02}) begin
            n_fail++; $display("FAIL sdiv_100_m7: got %h expected f202", {tb_bus.quotient, tb_bus.remainder}); end
        do_start(8'h80, 8'hFF);
        wait_done(0, cyc, bmap);
        n_checks++; if ({tb_bus.quotient, tb_bus.remainder, tb_bus.dvz} !== {8'h80, 8'h00, 1'b0}) begin
            n_fail++; $display("FAIL sdiv_overflow: got %h expected 10000", {tb_bus.quotient, tb_bus.remainder, tb_bus.dvz}); end
    endtask
`endif

    initial begin
        tb_bus.start     = 1'b0;
        tb_bus.dvdnd_val = 8'd0;
        tb_bus.dvsr_val  = 8'd0;
        test_reset();
        test_basic();
        test_hold();
        test_div_zero();
        test_back_to_back();
        test_abort_reset();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
